// File: rtl/clk_div_ctrl_if.sv
// Handshake and status bundle for clk_div_ctrl: run request, divide-value
// offer/accept, and the divided-clock outputs.
interface clk_div_ctrl_if #(
  parameter int W = 8
) ();
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         fout;
  logic         tick;
  logic         busy;
  logic [W-1:0] cur_div;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, fout, tick, busy, cur_div
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, fout, tick, busy, cur_div
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: fout has a half-period of cur_div fin cycles,
// and new divide values only take effect at a period boundary (no runt phases).
module clk_div_ctrl #(
  parameter int W = 8
) (
  input  logic          fin,
  input  logic          rst,
  clk_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] RESET_DIV = W'(2);

  state_t       state_q, state_d;
  logic         fout_q, fout_d;
  logic         tick_q, tick_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic [W-1:0] pend_q, pend_d;

  logic         cfg_ready;
  logic         xfer;
  logic         half_done;
  logic         boundary;
  logic [W-1:0] cfg_sat;

  // A zero half-period is meaningless; clamp so the fastest output is fin/2.
  function automatic logic [W-1:0] sat_div(input logic [W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  assign cfg_ready = (state_q != PEND);
  assign xfer      = bus.cfg_valid & cfg_ready;
  assign cfg_sat   = sat_div(bus.cfg_div);
  assign half_done = (cnt_q == (cur_div_q - ONE));
  assign boundary  = half_done & ~fout_q;

  always_comb begin
    state_d   = state_q;
    fout_d    = fout_q;
    tick_d    = 1'b0;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;

    unique case (state_q)
      IDLE: begin
        fout_d = 1'b0;
        cnt_d  = '0;
        if (xfer) begin
          cur_div_d = cfg_sat;
        end
        if (bus.en) begin
          state_d = RUN;
          fout_d  = 1'b1;
          tick_d  = 1'b1;
        end
      end

      RUN, PEND: begin
        if (half_done) begin
          cnt_d = '0;
          if (fout_q) begin
            fout_d = 1'b0;
          end else begin
            // End of a full period: the only point a new divide may land.
            if (state_q == PEND) begin
              cur_div_d = pend_q;
            end else if (xfer) begin
              cur_div_d = cfg_sat;
            end
            if (bus.en) begin
              state_d = RUN;
              fout_d  = 1'b1;
              tick_d  = 1'b1;
            end else begin
              state_d = IDLE;
              fout_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end

        if (xfer && !boundary) begin
          pend_d  = cfg_sat;
          state_d = PEND;
        end
      end

      default: begin
        state_d = IDLE;
        fout_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge fin) begin
    if (rst) begin
      state_q   <= IDLE;
      fout_q    <= 1'b0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      cur_div_q <= RESET_DIV;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      fout_q    <= fout_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.busy      = (state_q == PEND);
  assign bus.fout      = fout_q;
  assign bus.tick      = tick_q;
  assign bus.cur_div   = cur_div_q;

  // tick marks a rising edge of fout, so it always arrives with fout high
  // and can never repeat on the next cycle (fout must go low in between).
  a_tick_with_fout: assert property (@(posedge fin) disable iff (rst)
    tick_q |-> fout_q);
  a_tick_isolated: assert property (@(posedge fin) disable iff (rst)
    tick_q |=> !tick_q);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-position reference model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_clk_div_ctrl;

  logic fin;
  logic rst;

  clk_div_ctrl_if #(.W(8)) bus ();

  clk_div_ctrl #(.W(8)) dut (
    .fin (fin),
    .rst (rst),
    .bus (bus)
  );

  initial fin = 1'b0;
  always #5 fin = ~fin;

  typedef struct packed {
    logic       fout;
    logic       tick;
    logic       busy;
    logic       ready;
    logic [7:0] cur;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  // Reference model: a period is 2*div cycles, position pos counts through it.
  bit   m_run;
  int   m_div;
  int   m_pos;
  int   m_pend[$];
  bit   last_xfer;
  bit   en_cur;

  task automatic model_step(input bit r, input bit e, input bit v, input logic [7:0] d);
    bit rdy;
    bit xf;
    int val;
    last_xfer = 1'b0;
    if (r) begin
      m_run = 1'b0;
      m_pos = 0;
      m_div = 2;
      m_pend.delete();
    end else begin
      rdy = (m_pend.size() == 0);
      xf  = v && rdy;
      val = (d == 8'd0) ? 1 : int'(d);
      last_xfer = xf;
      if (!m_run) begin
        if (xf) m_div = val;
        if (e) begin
          m_run = 1'b1;
          m_pos = 0;
        end
      end else if (m_pos == 2 * m_div - 1) begin
        if (m_pend.size() != 0) m_div = m_pend.pop_front();
        else if (xf)            m_div = val;
        m_pos = 0;
        m_run = e;
      end else begin
        m_pos++;
        if (xf) m_pend.push_back(val);
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit v, input logic [7:0] d);
    exp_t x;
    @(negedge fin);
    rst           = r;
    bus.en        = e;
    bus.cfg_valid = v;
    bus.cfg_div   = d;
    model_step(r, e, v, d);
    x.fout  = m_run && (m_pos < m_div);
    x.tick  = m_run && (m_pos == 0);
    x.busy  = (m_pend.size() != 0);
    x.ready = (m_pend.size() == 0);
    x.cur   = 8'(m_div);
    sb.push_back(x);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, en_cur, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    en_cur = 1'b0;
  endtask

  // Offer a divide value and hold it until the model reports it accepted.
  task automatic offer(input logic [7:0] d);
    int guard = 0;
    do begin
      step(1'b0, en_cur, 1'b1, d);
      guard++;
    end while (!last_xfer && guard < 200);
    if (!last_xfer) begin
      miscompares++;
      $display("FAIL offer_timeout: cfg_div=%0d never accepted, required acceptance within 200 cycles", d);
    end
  endtask

  // Advance until the upcoming cycle sits at period position p while running.
  task automatic wait_pos(input int p);
    int guard = 0;
    while (!(m_run && m_pos == p) && guard < 200) begin
      step(1'b0, en_cur, 1'b0, 8'd0);
      guard++;
    end
    if (!(m_run && m_pos == p)) begin
      miscompares++;
      $display("FAIL wait_pos: position %0d not reached, required within 200 cycles", p);
    end
  endtask

  exp_t got;
  exp_t want;
  int   cyc_no;

  always @(posedge fin) begin
    #1;
    cyc_no++;
    if (sb.size() != 0) begin
      want = sb.pop_front();
      got.fout  = bus.fout;
      got.tick  = bus.tick;
      got.busy  = bus.busy;
      got.ready = bus.cfg_ready;
      got.cur   = bus.cur_div;
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL cycle%0d: got fout=%b tick=%b busy=%b ready=%b cur_div=%0d, required fout=%b tick=%b busy=%b ready=%b cur_div=%0d",
                 cyc_no, got.fout, got.tick, got.busy, got.ready, got.cur,
                 want.fout, want.tick, want.busy, want.ready, want.cur);
      end
    end
  end

  initial begin
    bit         rq_v;
    logic [7:0] rq_d;
    bit         r;
    int         guard;

    vectors       = 0;
    miscompares   = 0;
    cyc_no        = 0;
    m_run         = 1'b0;
    m_div         = 2;
    m_pos         = 0;
    en_cur        = 1'b0;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = 8'd0;

    // Reset, then free-run at fin/4.
    do_reset();
    en_cur = 1'b1;
    idle_cycles(12);

    // Config 5 offered one cycle after tick: held pending to the boundary.
    wait_pos(1);
    offer(8'd5);
    idle_cycles(24);

    // Back to div 2, then a transfer of 4 landing on the boundary cycle.
    offer(8'd2);
    wait_pos(0);
    wait_pos(3);
    offer(8'd4);
    idle_cycles(18);

    // At div 3, drop en one cycle after tick: period completes, then idle.
    offer(8'd3);
    wait_pos(0);
    wait_pos(1);
    en_cur = 1'b0;
    idle_cycles(12);

    // Zero divide in IDLE clamps to 1; run at fin/2.
    offer(8'd0);
    en_cur = 1'b1;
    idle_cycles(10);

    // Reset while a config is pending mid-period.
    en_cur = 1'b0;
    idle_cycles(4);
    offer(8'd2);
    en_cur = 1'b1;
    wait_pos(1);
    offer(8'd5);
    step(1'b1, 1'b1, 1'b0, 8'd0);
    en_cur = 1'b0;
    idle_cycles(3);

    // Enable plus simultaneous transfer from IDLE.
    step(1'b0, 1'b1, 1'b1, 8'd6);
    en_cur = 1'b1;
    idle_cycles(14);

    // Randomized traffic obeying the hold-until-ready protocol.
    rq_v = 1'b0;
    rq_d = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) en_cur = ~en_cur;
      if (!rq_v && $urandom_range(0, 5) == 0) begin
        rq_v = 1'b1;
        rq_d = 8'($urandom_range(0, 6));
      end
      step(r, en_cur, rq_v, rq_d);
      if (last_xfer) rq_v = 1'b0;
    end

    step(1'b0, 1'b0, 1'b0, 8'd0);
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(negedge fin);
      guard++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
